// File: rtl/bus88_pkg.sv
// Shared types and constants for the 8088-style bus master and its helpers.
package bus88_pkg;

    localparam int unsigned BUS_ADDR_WIDTH = 20;
    localparam int unsigned BUS_DATA_WIDTH = 8;

    // Wide enough to be truncated to any supported data width and stay all ones.
    localparam logic [63:0] TIMEOUT_DATA = '1;

    typedef enum logic [5:0] {
        IDLE = 6'b000001,
        T1   = 6'b000010,
        T2   = 6'b000100,
        T3   = 6'b001000,
        TW   = 6'b010000,
        T4   = 6'b100000
    } BusState_t;

endpackage

// File: rtl/bus88_wait_counter.sv
// Saturating count of consecutive wait states; at_max flags the timeout limit.
module bus88_wait_counter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [7:0] count;
    logic [7:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (clear)
            count_nxt = 8'd0;
        else if (inc && count != 8'hFF)
            count_nxt = count + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count  <= 8'd0;
            at_max <= 1'b0;
        end else begin
            count  <= count_nxt;
            at_max <= (count_nxt == 8'(MAX_WAIT));
        end
    end

endmodule

// File: rtl/bus88_cycle_initiator.sv
// Bus-master cycle engine: turns single host requests into T1/T2/T3/TW*/T4 bus cycles.
module bus88_cycle_initiator
    import bus88_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  Req,
    input  logic                  ReqWrite,
    input  logic                  ReqIOM,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0] ReqWData,
    output logic                  ReqReady,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Timeout,
    input  logic                  READY,
    output logic                  CS,
    output logic                  OE,
    output logic                  WR,
    output logic                  IOM,
    output logic [ADDR_WIDTH-1:0] Address,
    inout  wire  [DATA_WIDTH-1:0] Data
);

    BusState_t             state;
    BusState_t             state_nxt;
    logic                  accept_c;
    logic                  timeout_c;
    logic                  wait_inc_c;
    logic                  wait_clr_c;
    logic                  wait_at_max;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  data_oe;

    bus88_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (wait_clr_c),
        .inc    (wait_inc_c),
        .at_max (wait_at_max)
    );

    assign wait_clr_c = (state == T1);

    // Next-state decode; READY only matters in T3/TW.
    always_comb begin
        state_nxt  = state;
        accept_c   = Req && ReqReady;
        timeout_c  = 1'b0;
        wait_inc_c = 1'b0;
        case (state)
            IDLE: if (accept_c) state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
            T3, TW: begin
                if (READY) begin
                    state_nxt = T4;
                end else if (state == TW && wait_at_max) begin
                    state_nxt = T4;
                    timeout_c = 1'b1;
                end else begin
                    state_nxt  = TW;
                    wait_inc_c = 1'b1;
                end
            end
            T4:      state_nxt = accept_c ? T1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus bus/host outputs registered from the next state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            CS       <= 1'b0;
            OE       <= 1'b1;
            WR       <= 1'b1;
            IOM      <= 1'b0;
            Address  <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            data_oe  <= 1'b0;
            ReqReady <= 1'b0;
            Done     <= 1'b0;
            Timeout  <= 1'b0;
            RData    <= '0;
        end else begin
            state <= state_nxt;
            if (accept_c) begin
                write_q <= ReqWrite;
                IOM     <= ReqIOM;
                Address <= ReqAddr;
                wdata_q <= ReqWData;
            end
            CS       <= (state_nxt != IDLE);
            OE       <= !(!write_q && (state_nxt inside {T2, T3, TW}));
            WR       <= !(write_q && (state_nxt inside {T2, T3, TW}));
            data_oe  <= write_q && (state_nxt inside {T2, T3, TW, T4});
            ReqReady <= (state_nxt inside {IDLE, T4});
            Done     <= (state_nxt == T4);
            Timeout  <= timeout_c;
            if ((state == T3 || state == TW) && READY)
                RData <= Data;
            else if (timeout_c)
                RData <= DATA_WIDTH'(TIMEOUT_DATA);
        end
    end

    assign Data = data_oe ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus88_cycle_initiator.sv
// Directed bench for bus88_cycle_initiator with a byte-wide responder and a completion scoreboard.
module tb_bus88_cycle_initiator;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Req;
    logic        ReqWrite;
    logic        ReqIOM;
    logic [19:0] ReqAddr;
    logic [7:0]  ReqWData;
    logic        ReqReady;
    logic        Done;
    logic [7:0]  RData;
    logic        Timeout;
    logic        READY;
    logic        CS;
    logic        OE;
    logic        WR;
    logic        IOM;
    logic [19:0] Address;
    wire  [7:0]  Data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string      tag;
        logic [7:0] rdata;
        logic       chk_rdata;
        logic       timeout;
        int         acc;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [7:0] mem [0:1048575];

    bus88_cycle_initiator #(
        .ADDR_WIDTH (20),
        .DATA_WIDTH (8),
        .MAX_WAIT   (4)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Req      (Req),
        .ReqWrite (ReqWrite),
        .ReqIOM   (ReqIOM),
        .ReqAddr  (ReqAddr),
        .ReqWData (ReqWData),
        .ReqReady (ReqReady),
        .Done     (Done),
        .RData    (RData),
        .Timeout  (Timeout),
        .READY    (READY),
        .CS       (CS),
        .OE       (OE),
        .WR       (WR),
        .IOM      (IOM),
        .Address  (Address),
        .Data     (Data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Responder: drives read data while OE is low, stores writes while WR is low.
    assign Data = (CS && !OE) ? mem[Address] : 8'bzzzzzzzz;

    wire data_is_z = (Data === 8'bzzzzzzzz);

    always @(posedge CLK) begin
        if (!RESET)
            mem[20'h12345] <= 8'hA5;
        else if (CS && !WR)
            mem[Address] <= Data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_done(input string tag, input logic [7:0] rdata, input logic chk,
                               input logic to, input int lat);
        exp_t e;
        e.tag       = tag;
        e.rdata     = rdata;
        e.chk_rdata = chk;
        e.timeout   = to;
        e.acc       = cyc + 1;
        e.lat       = lat;
        sb.push_back(e);
    endtask

    task automatic request(input logic wr, input logic iom, input logic [19:0] addr,
                           input logic [7:0] wdata);
        Req      = 1'b1;
        ReqWrite = wr;
        ReqIOM   = iom;
        ReqAddr  = addr;
        ReqWData = wdata;
    endtask

    // Scoreboard: every Done must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && Done === 1'b1) begin
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_timeout"}, 32'(Timeout), 32'(mon_e.timeout));
                check({mon_e.tag, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
                if (mon_e.chk_rdata)
                    check({mon_e.tag, "_rdata"}, 32'(RData), 32'(mon_e.rdata));
            end
        end
    end

    initial begin
        RESET = 1'b0; Req = 1'b0; ReqWrite = 1'b0; ReqIOM = 1'b0;
        ReqAddr = '0; ReqWData = '0; READY = 1'b1;
        tick(); tick();

        check("rst_cs", 32'(CS), 32'd0);
        check("rst_oe_wr", {30'd0, OE, WR}, 32'd3);
        check("rst_iom", 32'(IOM), 32'd0);
        check("rst_addr", 32'(Address), 32'd0);
        check("rst_data_z", 32'(data_is_z), 32'd1);
        check("rst_done_to", {30'd0, Done, Timeout}, 32'd0);
        check("rst_rdata", 32'(RData), 32'd0);
        check("rst_reqready", 32'(ReqReady), 32'd0);
        RESET = 1'b1;
        tick();
        check("idle_reqready", 32'(ReqReady), 32'd1);

        // Memory read, no waits.
        request(1'b0, 1'b0, 20'h12345, 8'h00);
        expect_done("mem_read", 8'hA5, 1'b1, 1'b0, 4);
        tick(); Req = 1'b0;
        check("rd_t1_cs", 32'(CS), 32'd1);
        check("rd_t1_oe", 32'(OE), 32'd1);
        check("rd_t1_addr", 32'(Address), 32'h12345);
        check("rd_t1_reqready", 32'(ReqReady), 32'd0);
        tick(); check("rd_t2_oe", 32'(OE), 32'd0);
        tick(); check("rd_t3_oe", 32'(OE), 32'd0);
        check("rd_t3_data_driven_by_resp", 32'(Data), 32'hA5);
        tick(); check("rd_t4_oe", 32'(OE), 32'd1);
        check("rd_t4_cs", 32'(CS), 32'd1);
        check("rd_t4_done", 32'(Done), 32'd1);
        tick(); check("rd_idle_cs", 32'(CS), 32'd0);
        check("rd_idle_done", 32'(Done), 32'd0);

        // I/O write.
        request(1'b1, 1'b1, 20'h003F8, 8'h5C);
        expect_done("io_write", 8'h00, 1'b0, 1'b0, 4);
        tick(); Req = 1'b0;
        check("wr_t1_iom", 32'(IOM), 32'd1);
        check("wr_t1_wr", 32'(WR), 32'd1);
        check("wr_t1_data_z", 32'(data_is_z), 32'd1);
        tick(); check("wr_t2_wr", 32'(WR), 32'd0);
        check("wr_t2_data", 32'(Data), 32'h5C);
        tick(); check("wr_t3_wr", 32'(WR), 32'd0);
        check("wr_t3_oe", 32'(OE), 32'd1);
        tick(); check("wr_t4_wr", 32'(WR), 32'd1);
        check("wr_t4_data", 32'(Data), 32'h5C);
        tick(); check("wr_idle_data_z", 32'(data_is_z), 32'd1);
        check("wr_mem", 32'(mem[20'h003F8]), 32'h5C);

        // Read with three wait states.
        request(1'b0, 1'b1, 20'h003F8, 8'h00);
        expect_done("wait_read", 8'h5C, 1'b1, 1'b0, 7);
        tick(); Req = 1'b0;
        tick();
        tick(); READY = 1'b0;
        tick(); check("tw1_oe", 32'(OE), 32'd0);
        check("tw1_reqready", 32'(ReqReady), 32'd0);
        tick(); check("tw2_oe", 32'(OE), 32'd0);
        tick(); check("tw3_oe", 32'(OE), 32'd0);
        check("tw3_done", 32'(Done), 32'd0);
        READY = 1'b1;
        tick(); check("wait_t4_done", 32'(Done), 32'd1);
        tick();

        // Timeout after exactly MAX_WAIT=4 wait states.
        request(1'b0, 1'b0, 20'h12345, 8'h00);
        expect_done("timeout_read", 8'hFF, 1'b1, 1'b1, 8);
        tick(); Req = 1'b0;
        tick();
        tick(); READY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_tw%0d_oe_done", i + 1), {30'd0, OE, Done}, 32'd0);
        end
        tick(); check("to_t4_done_timeout", {30'd0, Done, Timeout}, 32'd3);
        check("to_t4_rdata", 32'(RData), 32'hFF);
        READY = 1'b1;
        tick();
        request(1'b0, 1'b0, 20'h12345, 8'h00);
        expect_done("after_timeout", 8'hA5, 1'b1, 1'b0, 4);
        tick(); Req = 1'b0;
        tick(); tick(); tick();
        check("after_to_timeout_low", 32'(Timeout), 32'd0);
        tick();

        // Back-to-back with Req held high; inputs change while ReqReady=0.
        request(1'b1, 1'b0, 20'h00010, 8'h11);
        expect_done("b2b_w11", 8'h00, 1'b0, 1'b0, 4);
        tick();
        request(1'b1, 1'b0, 20'h00011, 8'h22);
        tick(); tick(); tick();
        check("b2b_t4a_reqready", 32'(ReqReady), 32'd1);
        check("b2b_t4a_addr", 32'(Address), 32'h00010);
        expect_done("b2b_w22", 8'h00, 1'b0, 1'b0, 4);
        tick();
        check("b2b_t1b_data_z", 32'(data_is_z), 32'd1);
        check("b2b_t1b_addr", 32'(Address), 32'h00011);
        request(1'b0, 1'b0, 20'h00010, 8'h00);
        tick(); tick(); tick();
        expect_done("b2b_rd", 8'h11, 1'b1, 1'b0, 4);
        tick(); Req = 1'b0;
        check("b2b_t1c_addr", 32'(Address), 32'h00010);
        tick(); tick(); tick();
        tick();
        check("b2b_mem11", 32'(mem[20'h00011]), 32'h22);

        // Reset during TW of a write: the request is dropped without a Done.
        request(1'b1, 1'b0, 20'h00020, 8'h77);
        tick(); Req = 1'b0;
        tick();
        tick(); READY = 1'b0;
        tick(); tick();
        check("rst_mid_pre_wr", 32'(WR), 32'd0);
        RESET = 1'b0;
        tick();
        check("rst_mid_cs", 32'(CS), 32'd0);
        check("rst_mid_oe_wr", {30'd0, OE, WR}, 32'd3);
        check("rst_mid_data_z", 32'(data_is_z), 32'd1);
        check("rst_mid_done", 32'(Done), 32'd0);
        RESET = 1'b1; READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rst_mid_nodone%0d", i), 32'(Done), 32'd0);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
